cpmg_hbridge_seq: RTL and testbench
===================================

# cpmg_hbridge_seq

Parametrised CPMG pulse-sequence engine for the transmitter H-bridge. It replaces the fixed single-pulse bridge drive with a programmable echo train: one 90° pulse, then N 180° pulses, each followed by a damping window and an acquisition window. It runs from the system clock and feeds the bridge gate pairs, the damping switch and the ADC acquisition gate.

## Interface
Parameters:
- CNT_W, 16: width of every duration field, counted in SYSCLK cycles.
- NE_W, 12: width of echo count and echo index.
- HP_W, 8: width of carrier half-period and dead-time fields.

Ports:
- SYSCLK  in  1  system clock; all logic is on the rising edge.
- NSYSRESET  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to launch a sequence.
- abort  in  1  one-cycle request to terminate a running sequence.
- t90  in  CNT_W  90° pulse length.
- t180  in  CNT_W  180° pulse length.
- t_damp  in  CNT_W  damping window after each pulse.
- t_wait  in  CNT_W  gap between the 90° damp window and the first 180° pulse.
- t_acq  in  CNT_W  acquisition window after each 180° damp window.
- half_per  in  HP_W  carrier half-period.
- dead  in  HP_W  dead-time cycles at the start of each carrier half.
- n_echo  in  NE_W  number of 180° pulses.
- cpmg_ph  in  1  when 1, 180° pulses start on drv_n; when 0, they start on drv_p.
- drv_p  out  1  bridge leg pair A (Q1Q8/Q4Q5 side).
- drv_n  out  1  bridge leg pair B (Q2Q7/Q3Q6 side).
- damp_on  out  1  damping switch.
- acq_en  out  1  ADC acquisition gate.
- busy  out  1  a sequence is active.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- echo_idx  out  NE_W  index of the current 180° pulse, counted from 1.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset forces all outputs low immediately, in any state.
- Configuration inputs are latched into shadow registers on an accepted start. Changes to those inputs while busy have no effect.
- A start is rejected, with a cfg_err pulse and no state change, if any of the following is zero: t90, t180, half_per, n_echo. It is also rejected if dead ≥ half_per.
- A start while busy is ignored, with no cfg_err.
- State sequence: IDLE → P90 → DAMP90 → WAIT → {P180 → DAMP180 → ACQ} × n_echo → IDLE.
- Each state lasts exactly its latched length. A length of zero for t_damp, t_wait or t_acq skips that state; the state is present for 0 cycles.
- Carrier, active only in P90 and P180:
  - The active leg alternates every half_per cycles.
  - The first `dead` cycles of each half have both legs low.
  - P90 starts on drv_p. P180 starts on the leg chosen by cpmg_ph.
  - The carrier phase restarts at the beginning of every pulse.
- drv_p and drv_n are never high in the same cycle.
- damp_on is high throughout DAMP90 and DAMP180. acq_en is high throughout ACQ.
- echo_idx is set to k on entry to the k-th P180, holds through the following ACQ, and clears to 0 in IDLE.
- done pulses in the cycle after the last ACQ cycle, together with busy falling.
- Abort in any non-IDLE state:
  - Drive stops next cycle.
  - State enters ABORT_DAMP for t_damp cycles, with damp_on high.
  - Then state returns to IDLE, aborted pulses, and done does not pulse.
  - Abort in ABORT_DAMP or IDLE is ignored.
  - Start and abort in the same cycle while IDLE: start wins.

## Timing
- Start accepted in cycle 0:
  - busy = 1 from cycle 1.
  - The first P90 cycle is cycle 1; drv_p is high at cycle 1 + dead.
- Total active cycles: t90 + t_damp + t_wait + n_echo·(t180 + t_damp + t_acq).
- Counters saturate; there is no wrap. Duration counters count down to 1, then the state advances.
- Carrier half counter width is HP_W. Pulse counters are CNT_W wide; echo counter is NE_W wide.

## Structure
- Package nmr_seq_pkg: state enum, default widths, and the cfg struct of shadow registers.
- Sub-module hb_carrier: takes the half_per/dead/start-leg settings, a restart strobe and an enable, and outputs drv_p and drv_n. The top-level FSM instantiates one hb_carrier.

## Test plan
- Carrier pattern: t90=8, half_per=2, dead=1, n_echo=1, all other lengths 1 → P90 gives drv_p/drv_n per cycle as 0,1,0,0 repeated (drv_p high in cycles 2 and 6, drv_n high in cycles 4 and 8); the two legs never overlap.
- Full train: t90=4, t180=8, t_damp=3, t_wait=5, t_acq=10, n_echo=3 → busy lasts 75 cycles; acq_en has three windows of 10 cycles; echo_idx steps 1, 2, 3; done pulses once at cycle 76.
- cpmg_ph=1 → the first active carrier cycle of each P180 is drv_n; P90 still starts on drv_p.
- Abort during the 2nd ACQ with t_damp=3 → next cycle acq_en=0 and damp_on=1 for 3 cycles; then aborted pulses, busy drops, and done never asserts.
- Rejects: n_echo=0 → cfg_err pulse with busy staying 0; dead=2 with half_per=2 → cfg_err pulse; start while busy → no effect.
- NSYSRESET asserted mid-P180 → all outputs 0 asynchronously. After release, the block is in IDLE and a new start runs a normal sequence.

Source files
------------

// File: rtl/nmr_seq_pkg.sv
// nmr_seq_pkg
// Shared definitions for the CPMG H-bridge sequencer:
//   - default field widths (duration, echo count, carrier half-period)
//   - sequencer state encoding
//   - shadow-register configuration struct latched on an accepted start
//   - helpers: per-state segment length lookup and start validation
// The struct fields use the package default widths; the sequencer's
// width parameters default to the same values.
package nmr_seq_pkg;

  localparam int CNT_W_D = 16;
  localparam int NE_W_D  = 12;
  localparam int HP_W_D  = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_P90        = 3'd1,
    ST_DAMP90     = 3'd2,
    ST_WAIT       = 3'd3,
    ST_P180       = 3'd4,
    ST_DAMP180    = 3'd5,
    ST_ACQ        = 3'd6,
    ST_ABORT_DAMP = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic [CNT_W_D-1:0] t90;
    logic [CNT_W_D-1:0] t180;
    logic [CNT_W_D-1:0] t_damp;
    logic [CNT_W_D-1:0] t_wait;
    logic [CNT_W_D-1:0] t_acq;
    logic [HP_W_D-1:0]  half_per;
    logic [HP_W_D-1:0]  dead;
    logic [NE_W_D-1:0]  n_echo;
    logic               cpmg_ph;
  } seq_cfg_t;

  // Length of a timed state under a given configuration; 0 for IDLE.
  function automatic logic [CNT_W_D-1:0] seg_len(input seq_state_t st, input seq_cfg_t cfg);
    logic [CNT_W_D-1:0] len;
    case (st)
      ST_P90:        len = cfg.t90;
      ST_DAMP90:     len = cfg.t_damp;
      ST_WAIT:       len = cfg.t_wait;
      ST_P180:       len = cfg.t180;
      ST_DAMP180:    len = cfg.t_damp;
      ST_ACQ:        len = cfg.t_acq;
      ST_ABORT_DAMP: len = cfg.t_damp;
      default:       len = {CNT_W_D{1'b0}};
    endcase
    return len;
  endfunction

  // A start is accepted only with non-zero pulse lengths, carrier
  // half-period and echo count, and a dead time shorter than a half.
  function automatic logic cfg_valid(input seq_cfg_t cfg);
    return (|cfg.t90) && (|cfg.t180) && (|cfg.half_per) && (|cfg.n_echo) &&
           (cfg.dead < cfg.half_per);
  endfunction

endpackage

// File: rtl/hb_carrier.sv
// hb_carrier
// Carrier generator for the H-bridge gate pairs. Each carrier half lasts
// half_per cycles; the first `dead` cycles of every half keep both legs
// low, the rest drive the leg owning that half. Legs alternate per half.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           carrier runs in the coming cycle (otherwise legs low)
//   restart      coming cycle is the first of a pulse: phase restarts
//   start_leg    leg owning the first half after restart (0 = drv_p)
//   half_per     carrier half-period in cycles (non-zero)
//   dead         dead-time cycles at the start of each half (< half_per)
//   drv_p/drv_n  registered leg drives, never high together
module hb_carrier
  import nmr_seq_pkg::*;
#(
  parameter int HP_W = HP_W_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            restart,
  input  logic            start_leg,
  input  logic [HP_W-1:0] half_per,
  input  logic [HP_W-1:0] dead,
  output logic            drv_p,
  output logic            drv_n
);

  localparam logic [HP_W-1:0] HP_ZERO = {HP_W{1'b0}};
  localparam logic [HP_W-1:0] HP_ONE  = {{(HP_W-1){1'b0}}, 1'b1};

  logic [HP_W-1:0] pos_r;
  logic [HP_W-1:0] pos_s;
  logic            leg_r;
  logic            leg_s;
  logic            act_s;

  // Position within the half and owning leg for the coming cycle.
  always_comb begin
    if (restart) begin
      pos_s = HP_ZERO;
      leg_s = start_leg;
    end else if (pos_r >= (half_per - HP_ONE)) begin
      // ">=" keeps the counter bounded even if it were ever out of range
      pos_s = HP_ZERO;
      leg_s = ~leg_r;
    end else begin
      pos_s = pos_r + HP_ONE;
      leg_s = leg_r;
    end
  end

  assign act_s = en && (pos_s >= dead);

  // Carrier phase registers and registered leg drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_r <= HP_ZERO;
      leg_r <= 1'b0;
      drv_p <= 1'b0;
      drv_n <= 1'b0;
    end else if (en) begin
      pos_r <= pos_s;
      leg_r <= leg_s;
      drv_p <= act_s && !leg_s;
      drv_n <= act_s && leg_s;
    end else begin
      pos_r <= HP_ZERO;
      leg_r <= 1'b0;
      drv_p <= 1'b0;
      drv_n <= 1'b0;
    end
  end

endmodule

// File: rtl/cpmg_hbridge_seq.sv
// cpmg_hbridge_seq
// CPMG echo-train sequencer for the transmitter H-bridge:
//   IDLE -> P90 -> DAMP90 -> WAIT -> {P180 -> DAMP180 -> ACQ} x n_echo -> IDLE
// Zero-length DAMP/WAIT/ACQ segments are skipped. An abort moves to a
// damping window of t_damp cycles, then back to IDLE with an aborted pulse.
// Ports:
//   SYSCLK, NSYSRESET   clock, asynchronous active-low reset
//   start, abort        one-cycle launch / terminate requests
//   t90..t_acq          segment durations in SYSCLK cycles
//   half_per, dead      carrier half-period and dead time
//   n_echo, cpmg_ph     number of 180 pulses, 180 starting leg (1 = drv_n)
//   drv_p, drv_n        bridge leg pairs A and B
//   damp_on, acq_en     damping switch, ADC acquisition gate
//   busy                sequence active
//   done/aborted/cfg_err one-cycle status pulses
//   echo_idx            current 180 pulse number, from 1; 0 when idle
// All outputs are registered and cleared by reset.
module cpmg_hbridge_seq
  import nmr_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_D,
  parameter int NE_W  = NE_W_D,
  parameter int HP_W  = HP_W_D
) (
  input  logic             SYSCLK,
  input  logic             NSYSRESET,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] t90,
  input  logic [CNT_W-1:0] t180,
  input  logic [CNT_W-1:0] t_damp,
  input  logic [CNT_W-1:0] t_wait,
  input  logic [CNT_W-1:0] t_acq,
  input  logic [HP_W-1:0]  half_per,
  input  logic [HP_W-1:0]  dead,
  input  logic [NE_W-1:0]  n_echo,
  input  logic             cpmg_ph,
  output logic             drv_p,
  output logic             drv_n,
  output logic             damp_on,
  output logic             acq_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [NE_W-1:0]  echo_idx
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NE_W-1:0]  NE_ZERO  = {NE_W{1'b0}};
  localparam logic [NE_W-1:0]  NE_ONE   = {{(NE_W-1){1'b0}}, 1'b1};

  seq_cfg_t         cfg_r;
  seq_cfg_t         cfg_in_s;
  seq_state_t       state_r;
  seq_state_t       nxt_state_s;
  seq_state_t       succ_raw_s;
  seq_state_t       skip1_s;
  seq_state_t       skip2_s;
  seq_state_t       skip3_s;
  seq_state_t       succ_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] nxt_cnt_s;
  logic [NE_W-1:0]  idx_r;
  logic [NE_W-1:0]  nxt_idx_s;
  logic             accept_s;
  logic             pulse_go_s;
  logic             done_s;
  logic             aborted_s;
  logic             cfg_err_s;
  logic             last_echo_s;
  logic             echo_step_s;
  logic             carr_en_s;
  logic             carr_leg_s;
  logic [HP_W-1:0]  hp_use_s;
  logic [HP_W-1:0]  dead_use_s;
  logic             damp_on_r;
  logic             acq_en_r;
  logic             busy_r;
  logic             done_r;
  logic             aborted_r;
  logic             cfg_err_r;

  assign cfg_in_s = '{t90: t90, t180: t180, t_damp: t_damp, t_wait: t_wait,
                      t_acq: t_acq, half_per: half_per, dead: dead,
                      n_echo: n_echo, cpmg_ph: cpmg_ph};

  // Natural successor of each timed state; ST_IDLE out of ACQ marks the
  // end of an echo, resolved below into the next P180 or completion.
  always_comb begin
    case (state_r)
      ST_P90:     succ_raw_s = ST_DAMP90;
      ST_DAMP90:  succ_raw_s = ST_WAIT;
      ST_WAIT:    succ_raw_s = ST_P180;
      ST_P180:    succ_raw_s = ST_DAMP180;
      ST_DAMP180: succ_raw_s = ST_ACQ;
      ST_ACQ:     succ_raw_s = ST_IDLE;
      default:    succ_raw_s = ST_IDLE;
    endcase
  end

  // Zero-length segments are passed over in order so they take no cycles.
  assign skip1_s = ((succ_raw_s == ST_DAMP90)  && !(|cfg_r.t_damp)) ? ST_WAIT : succ_raw_s;
  assign skip2_s = ((skip1_s    == ST_WAIT)    && !(|cfg_r.t_wait)) ? ST_P180 : skip1_s;
  assign skip3_s = ((skip2_s    == ST_DAMP180) && !(|cfg_r.t_damp)) ? ST_ACQ  : skip2_s;
  assign succ_s  = ((skip3_s    == ST_ACQ)     && !(|cfg_r.t_acq))  ? ST_IDLE : skip3_s;

  assign last_echo_s = (succ_s == ST_IDLE) && (idx_r == cfg_r.n_echo);
  assign echo_step_s = (succ_s == ST_IDLE) || (succ_s == ST_P180);

  // Sequencer next state, duration counter, echo index and status events.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_idx_s   = idx_r;
    accept_s    = 1'b0;
    pulse_go_s  = 1'b0;
    done_s      = 1'b0;
    aborted_s   = 1'b0;
    cfg_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // start has priority over abort here; abort is meaningless in IDLE
        nxt_idx_s = NE_ZERO;
        if (start && cfg_valid(cfg_in_s)) begin
          accept_s    = 1'b1;
          pulse_go_s  = 1'b1;
          nxt_state_s = ST_P90;
          nxt_cnt_s   = cfg_in_s.t90;
        end else if (start) begin
          cfg_err_s = 1'b1;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_ABORT_DAMP: begin
        if (cnt_r == CNT_ONE) begin
          nxt_state_s = ST_IDLE;
          nxt_cnt_s   = CNT_ZERO;
          nxt_idx_s   = NE_ZERO;
          aborted_s   = 1'b1;
        end else begin
          nxt_cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        if (abort) begin
          if (|cfg_r.t_damp) begin
            nxt_state_s = ST_ABORT_DAMP;
            nxt_cnt_s   = cfg_r.t_damp;
          end else begin
            nxt_state_s = ST_IDLE;
            nxt_cnt_s   = CNT_ZERO;
            nxt_idx_s   = NE_ZERO;
            aborted_s   = 1'b1;
          end
        end else if (cnt_r != CNT_ONE) begin
          nxt_cnt_s = cnt_r - CNT_ONE;
        end else if (last_echo_s) begin
          nxt_state_s = ST_IDLE;
          nxt_cnt_s   = CNT_ZERO;
          nxt_idx_s   = NE_ZERO;
          done_s      = 1'b1;
        end else if (echo_step_s) begin
          // idx_r < n_echo here, so the increment cannot wrap
          nxt_state_s = ST_P180;
          nxt_cnt_s   = cfg_r.t180;
          nxt_idx_s   = idx_r + NE_ONE;
          pulse_go_s  = 1'b1;
        end else begin
          nxt_state_s = succ_s;
          nxt_cnt_s   = seg_len(succ_s, cfg_r);
        end
      end
    endcase
  end

  // On the accepting edge the shadow registers are not loaded yet, so the
  // carrier takes its settings straight from the inputs for that cycle.
  assign hp_use_s   = accept_s ? half_per : cfg_r.half_per;
  assign dead_use_s = accept_s ? dead     : cfg_r.dead;
  assign carr_en_s  = (nxt_state_s == ST_P90) || (nxt_state_s == ST_P180);
  assign carr_leg_s = (nxt_state_s == ST_P180) ? cfg_r.cpmg_ph : 1'b0;

  hb_carrier #(
    .HP_W (HP_W)
  ) u_carrier (
    .clk       (SYSCLK),
    .rst_n     (NSYSRESET),
    .en        (carr_en_s),
    .restart   (pulse_go_s),
    .start_leg (carr_leg_s),
    .half_per  (hp_use_s),
    .dead      (dead_use_s),
    .drv_p     (drv_p),
    .drv_n     (drv_n)
  );

  // State, shadow configuration and registered outputs.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      idx_r     <= NE_ZERO;
      cfg_r     <= {$bits(seq_cfg_t){1'b0}};
      damp_on_r <= 1'b0;
      acq_en_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      idx_r   <= nxt_idx_s;
      if (accept_s) begin
        cfg_r <= cfg_in_s;
      end
      damp_on_r <= (nxt_state_s == ST_DAMP90) || (nxt_state_s == ST_DAMP180) ||
                   (nxt_state_s == ST_ABORT_DAMP);
      acq_en_r  <= (nxt_state_s == ST_ACQ);
      busy_r    <= (nxt_state_s != ST_IDLE);
      done_r    <= done_s;
      aborted_r <= aborted_s;
      cfg_err_r <= cfg_err_s;
    end
  end

  assign damp_on  = damp_on_r;
  assign acq_en   = acq_en_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign aborted  = aborted_r;
  assign cfg_err  = cfg_err_r;
  assign echo_idx = idx_r;

endmodule

// File: tb/tb_cpmg_hbridge_seq.sv
// Testbench for cpmg_hbridge_seq. A cycle-level model expands each
// configuration into expected output vectors pushed into a queue at
// launch; every cycle one vector is popped and compared with the DUT.
// Vector layout: [20] ignore echo_idx, [19:12] {drv_p, drv_n, damp_on,
// acq_en, busy, done, aborted, cfg_err}, [11:0] echo_idx.
module tb_cpmg_hbridge_seq;

  logic        SYSCLK;
  logic        NSYSRESET;
  logic        start;
  logic        abort;
  logic [15:0] t90;
  logic [15:0] t180;
  logic [15:0] t_damp;
  logic [15:0] t_wait;
  logic [15:0] t_acq;
  logic [7:0]  half_per;
  logic [7:0]  dead;
  logic [11:0] n_echo;
  logic        cpmg_ph;
  logic        drv_p;
  logic        drv_n;
  logic        damp_on;
  logic        acq_en;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        cfg_err;
  logic [11:0] echo_idx;

  logic [20:0] exp_q[$];
  int          vectors;
  int          miscompares;
  int          cfg_damp;

  cpmg_hbridge_seq dut (
    .SYSCLK    (SYSCLK),
    .NSYSRESET (NSYSRESET),
    .start     (start),
    .abort     (abort),
    .t90       (t90),
    .t180      (t180),
    .t_damp    (t_damp),
    .t_wait    (t_wait),
    .t_acq     (t_acq),
    .half_per  (half_per),
    .dead      (dead),
    .n_echo    (n_echo),
    .cpmg_ph   (cpmg_ph),
    .drv_p     (drv_p),
    .drv_n     (drv_n),
    .damp_on   (damp_on),
    .acq_en    (acq_en),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .cfg_err   (cfg_err),
    .echo_idx  (echo_idx)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  task automatic push_v(input logic [7:0] flags, input logic [11:0] idx, input logic ign);
    exp_q.push_back({ign, flags, idx});
  endtask

  // Expected carrier for one pulse, phase counted from the pulse start.
  task automatic push_pulse(input int len, input int hp, input int dd, input logic leg0,
                            input logic [11:0] idx);
    for (int i = 0; i < len; i++) begin
      logic leg;
      logic act;
      leg = leg0 ^ (((i / hp) % 2) != 0);
      act = (i % hp) >= dd;
      push_v({act && !leg, act && leg, 6'b00_1000}, idx, 1'b0);
    end
  endtask

  // Drive a configuration with start; queue the expected response.
  task automatic launch(input int a90, input int a180, input int ad, input int aw, input int aa,
                        input int ahp, input int adead, input int an, input logic aph);
    t90      = 16'(a90);
    t180     = 16'(a180);
    t_damp   = 16'(ad);
    t_wait   = 16'(aw);
    t_acq    = 16'(aa);
    half_per = 8'(ahp);
    dead     = 8'(adead);
    n_echo   = 12'(an);
    cpmg_ph  = aph;
    cfg_damp = ad;
    start    = 1'b1;
    if (a90 > 0 && a180 > 0 && ahp > 0 && an > 0 && adead < ahp) begin
      push_pulse(a90, ahp, adead, 1'b0, 12'd0);
      for (int i = 0; i < ad; i++) push_v(8'b0010_1000, 12'd0, 1'b0);
      for (int i = 0; i < aw; i++) push_v(8'b0000_1000, 12'd0, 1'b0);
      for (int k = 1; k <= an; k++) begin
        push_pulse(a180, ahp, adead, aph, 12'(k));
        for (int i = 0; i < ad; i++) push_v(8'b0010_1000, 12'(k), 1'b0);
        for (int i = 0; i < aa; i++) push_v(8'b0001_1000, 12'(k), 1'b0);
      end
      push_v(8'b0000_0100, 12'd0, 1'b0);
    end else begin
      push_v(8'b0000_0001, 12'd0, 1'b0);
    end
    push_v(8'b0000_0000, 12'd0, 1'b0);
  endtask

  // Pop and compare one vector per cycle. abort_at / restart_at inject a
  // request after that cycle's check; stop_at ends the run early.
  task automatic run_check(input string name, input int abort_at, input int restart_at,
                           input int stop_at);
    int          cyc;
    logic [20:0] e;
    logic [7:0]  af;
    logic [11:0] hold_idx;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      @(posedge SYSCLK);
      #1;
      start = 1'b0;
      abort = 1'b0;
      cyc++;
      e  = exp_q.pop_front();
      af = {drv_p, drv_n, damp_on, acq_en, busy, done, aborted, cfg_err};
      vectors++;
      if (af !== e[19:12] || (!e[20] && echo_idx !== e[11:0])) begin
        miscompares++;
        $display("FAIL %s cyc %0d flags got %b exp %b idx got %0d exp %0d",
                 name, cyc, af, e[19:12], echo_idx, e[11:0]);
      end
      if (cyc == abort_at) begin
        abort    = 1'b1;
        hold_idx = e[11:0];
        exp_q.delete();
        for (int i = 0; i < cfg_damp; i++) push_v(8'b0010_1000, hold_idx, 1'b1);
        push_v(8'b0000_0010, 12'd0, 1'b0);
        push_v(8'b0000_0000, 12'd0, 1'b0);
        push_v(8'b0000_0000, 12'd0, 1'b0);
      end
      if (cyc == restart_at) begin
        start    = 1'b1;
        t90      = 16'd2;
        t_acq    = 16'd1;
        half_per = 8'd5;
        n_echo   = 12'd7;
      end
      if (cyc == stop_at) begin
        exp_q.delete();
        break;
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({drv_p, drv_n, damp_on, acq_en, busy, done, aborted, cfg_err, echo_idx} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset got %b exp 0",
               {drv_p, drv_n, damp_on, acq_en, busy, done, aborted, cfg_err, echo_idx});
    end
    @(posedge SYSCLK);
    #1;
    NSYSRESET = 1'b1;
  endtask

  task automatic test_carrier();
    launch(8, 1, 1, 1, 1, 2, 1, 1, 1'b0);
    run_check("carrier", 0, 0, 0);
  endtask

  task automatic test_full_train();
    launch(4, 8, 3, 5, 10, 2, 0, 3, 1'b0);
    run_check("full_train", 0, 0, 0);
  endtask

  task automatic test_cpmg_ph();
    launch(4, 6, 1, 1, 2, 3, 1, 2, 1'b1);
    run_check("cpmg_ph", 0, 0, 0);
  endtask

  task automatic test_abort();
    // second ACQ window of this train spans cycles 45..54
    launch(4, 8, 3, 5, 10, 2, 0, 3, 1'b0);
    run_check("abort_acq", 47, 0, 0);
  endtask

  task automatic test_skip_zero_len();
    launch(2, 3, 0, 0, 0, 1, 0, 2, 1'b0);
    run_check("skip_zero", 0, 0, 0);
    launch(2, 3, 0, 0, 0, 1, 0, 2, 1'b0);
    run_check("abort_nodamp", 4, 0, 0);
  endtask

  task automatic test_rejects();
    launch(4, 4, 1, 1, 1, 2, 0, 0, 1'b0);
    run_check("rej_necho0", 0, 0, 0);
    launch(4, 4, 1, 1, 1, 2, 2, 1, 1'b0);
    run_check("rej_dead", 0, 0, 0);
    launch(0, 4, 1, 1, 1, 2, 0, 1, 1'b0);
    run_check("rej_t90", 0, 0, 0);
    launch(4, 4, 1, 1, 1, 0, 0, 1, 1'b0);
    run_check("rej_hp0", 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    launch(5, 4, 2, 2, 3, 2, 1, 2, 1'b1);
    run_check("start_busy", 0, 8, 0);
    launch(3, 2, 1, 0, 2, 1, 0, 1, 1'b0);
    abort = 1'b1;
    run_check("start_abort_idle", 0, 0, 0);
  endtask

  task automatic test_async_reset();
    launch(4, 8, 3, 5, 10, 2, 0, 3, 1'b0);
    run_check("pre_reset", 0, 0, 15);
    #3;
    NSYSRESET = 1'b0;
    #1;
    vectors++;
    if ({drv_p, drv_n, damp_on, acq_en, busy, done, aborted, cfg_err, echo_idx} !== 20'd0) begin
      miscompares++;
      $display("FAIL async_reset got %b exp 0",
               {drv_p, drv_n, damp_on, acq_en, busy, done, aborted, cfg_err, echo_idx});
    end
    @(posedge SYSCLK);
    #1;
    NSYSRESET = 1'b1;
    launch(3, 4, 2, 1, 2, 2, 1, 2, 1'b0);
    run_check("post_reset", 0, 0, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cfg_damp    = 0;
    NSYSRESET   = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    t90         = 16'd0;
    t180        = 16'd0;
    t_damp      = 16'd0;
    t_wait      = 16'd0;
    t_acq       = 16'd0;
    half_per    = 8'd0;
    dead        = 8'd0;
    n_echo      = 12'd0;
    cpmg_ph     = 1'b0;
    #22;
    test_reset();
    test_carrier();
    test_full_train();
    test_cpmg_ph();
    test_abort();
    test_skip_zero_len();
    test_rejects();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
